// File: rtl/row_access_sequencer_if.sv
// Request handshake and row-path strobes between requester and sequencer.
// The sequencer takes the slave side; the requester/monitor takes master.
interface row_access_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_addr;
    logic [2:0] dec_addr_hi;
    logic [2:0] dec_addr_lo;
    logic       dec_en;
    logic       precharge_n;
    logic       wl_en;
    logic       sense_en;
    logic       busy;
    logic       done;

    modport master (
        output req_valid, req_addr,
        input  req_ready, dec_addr_hi, dec_addr_lo, dec_en,
        input  precharge_n, wl_en, sense_en, busy, done
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, dec_addr_hi, dec_addr_lo, dec_en,
        output precharge_n, wl_en, sense_en, busy, done
    );
endinterface

// File: rtl/row_access_sequencer.sv
// SRAM row-path sequencer: latches the row address and walks
// precharge -> wordline -> sense -> done with programmable lengths.
module row_access_sequencer #(
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3,
    parameter int SEN_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    row_access_sequencer_if.slave bus
);

    localparam int M1   = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int MAXC = (M1 > SEN_CYC) ? M1 : SEN_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WL,
        S_SENSE,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      addr_q, addr_d;
    logic            pre_n_q, pre_n_d;
    logic            wl_q, wl_d;
    logic            sen_q, sen_d;
    logic            done_q, done_d;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(PRE_CYC - 1);
                    addr_d  = bus.req_addr;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_WL;
                    cnt_d   = CW'(WL_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WL: begin
                if (cnt_zero) begin
                    state_d = S_SENSE;
                    cnt_d   = CW'(SEN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SENSE: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are flopped from the next state so they align with state_q.
    always_comb begin
        pre_n_d = (state_d == S_WL) || (state_d == S_SENSE);
        wl_d    = (state_d == S_WL);
        sen_d   = (state_d == S_SENSE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            pre_n_q <= 1'b0;
            wl_q    <= 1'b0;
            sen_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pre_n_q <= pre_n_d;
            wl_q    <= wl_d;
            sen_q   <= sen_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.dec_addr_hi = addr_q[5:3];
    assign bus.dec_addr_lo = addr_q[2:0];
    assign bus.dec_en      = wl_q;
    assign bus.wl_en       = wl_q;
    assign bus.precharge_n = pre_n_q;
    assign bus.sense_en    = sen_q;
    assign bus.done        = done_q;

endmodule
